// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU results or completes loads (with byte/half
// extraction and a bounded wait for memory) into the register-file write port.
module writeback_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_dest,
    input  logic [31:0] in_alu_result,
    input  logic        in_is_load,
    input  logic [2:0]  in_load_type,
    input  logic [1:0]  in_addr_low,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [4:0]  rf_write_addr,
    output logic [31:0] rf_data,
    output logic        addr_error,
    output logic        bus_error
);

    localparam int unsigned DEST_W = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] LT_LB  = 3'd0;
    localparam logic [2:0] LT_LBU = 3'd1;
    localparam logic [2:0] LT_LH  = 3'd2;
    localparam logic [2:0] LT_LHU = 3'd3;

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_e;

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [DEST_W-1:0]    dest_q, dest_d;
    logic [2:0]           type_q, type_d;
    logic [1:0]           addr_low_q, addr_low_d;
    logic [DEST_W-1:0]    rf_write_addr_q, rf_write_addr_d;
    logic [DATA_W-1:0]    rf_data_q, rf_data_d;
    logic                 addr_error_q, addr_error_d;
    logic                 bus_error_q, bus_error_d;

    logic                 accept;
    logic                 misaligned;
    logic [7:0]           load_byte;
    logic [15:0]          load_half;
    logic [DATA_W-1:0]    load_value;

    assign in_ready      = (state_q == IDLE);
    assign rf_write_addr = rf_write_addr_q;
    assign rf_data       = rf_data_q;
    assign addr_error    = addr_error_q;
    assign bus_error     = bus_error_q;

    assign accept = in_valid && in_ready;

    // Halfword loads need bit 0 clear; word loads (types 4-7) need both bits clear.
    always_comb begin
        misaligned = 1'b0;
        if (in_load_type == LT_LH || in_load_type == LT_LHU) begin
            misaligned = in_addr_low[0];
        end else if (in_load_type[2]) begin
            misaligned = (in_addr_low != 2'd0);
        end
    end

    // Little-endian lane selection and sign/zero extension of the returned word.
    always_comb begin
        load_byte = 8'(mem_rdata >> {addr_low_q, 3'b000});
        load_half = addr_low_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (type_q)
            LT_LB:   load_value = {{24{load_byte[7]}}, load_byte};
            LT_LBU:  load_value = {24'd0, load_byte};
            LT_LH:   load_value = {{16{load_half[15]}}, load_half};
            LT_LHU:  load_value = {16'd0, load_half};
            default: load_value = mem_rdata;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        dest_d          = dest_q;
        type_d          = type_q;
        addr_low_d      = addr_low_q;
        rf_write_addr_d = '0;
        rf_data_d       = rf_data_q;
        addr_error_d    = 1'b0;
        bus_error_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!in_is_load) begin
                        rf_write_addr_d = in_dest;
                        rf_data_d       = in_alu_result;
                    end else if (misaligned) begin
                        addr_error_d = 1'b1;
                    end else begin
                        dest_d     = in_dest;
                        type_d     = in_load_type;
                        addr_low_d = in_addr_low;
                        cnt_d      = '0;
                        state_d    = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_ready) begin
                    rf_write_addr_d = dest_q;
                    rf_data_d       = load_value;
                    state_d         = IDLE;
                end else if (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
                    bus_error_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            dest_q          <= '0;
            type_q          <= '0;
            addr_low_q      <= '0;
            rf_write_addr_q <= '0;
            rf_data_q       <= '0;
            addr_error_q    <= 1'b0;
            bus_error_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            dest_q          <= dest_d;
            type_q          <= type_d;
            addr_low_q      <= addr_low_d;
            rf_write_addr_q <= rf_write_addr_d;
            rf_data_q       <= rf_data_d;
            addr_error_q    <= addr_error_d;
            bus_error_q     <= bus_error_d;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed-vector bench for writeback_stage with a short load timeout.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_dest;
    logic [31:0] in_alu_result;
    logic        in_is_load;
    logic [2:0]  in_load_type;
    logic [1:0]  in_addr_low;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_data;
    logic        addr_error;
    logic        bus_error;

    int vec_cnt = 0;
    int err_cnt = 0;

    writeback_stage #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest),
        .in_alu_result(in_alu_result), .in_is_load(in_is_load),
        .in_load_type(in_load_type), .in_addr_low(in_addr_low),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .rf_write_addr(rf_write_addr), .rf_data(rf_data),
        .addr_error(addr_error), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one posedge, then settle 1 time unit before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".ready"}, 32'(in_ready), 32'd1);
        check({tag, ".wa"}, 32'(rf_write_addr), 32'd0);
        check({tag, ".aerr"}, 32'(addr_error), 32'd0);
        check({tag, ".berr"}, 32'(bus_error), 32'd0);
    endtask

    task automatic drive_alu(input logic [4:0] dest, input logic [31:0] val);
        in_valid      = 1'b1;
        in_is_load    = 1'b0;
        in_dest       = dest;
        in_alu_result = val;
    endtask

    task automatic drive_load(input logic [2:0] lt, input logic [1:0] al, input logic [4:0] dest);
        in_valid     = 1'b1;
        in_is_load   = 1'b1;
        in_load_type = lt;
        in_addr_low  = al;
        in_dest      = dest;
    endtask

    // Aligned load: wait_n cycles of mem_ready=0, then one cycle of mem_ready=1.
    task automatic run_load(input string tag, input logic [2:0] lt, input logic [1:0] al,
                            input logic [4:0] dest, input int wait_n,
                            input logic [31:0] rdata, input logic [31:0] exp);
        drive_load(lt, al, dest);
        check({tag, ".acc_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < wait_n; i++) begin
            mem_ready = 1'b0;
            check({tag, ".wait_ready"}, 32'(in_ready), 32'd0);
            check({tag, ".wait_wa"}, 32'(rf_write_addr), 32'd0);
            step();
        end
        mem_ready = 1'b1;
        mem_rdata = rdata;
        check({tag, ".mr_ready"}, 32'(in_ready), 32'd0);
        step();
        mem_ready = 1'b0;
        mem_rdata = 32'hA5A5_A5A5;
        check({tag, ".wa"}, 32'(rf_write_addr), 32'(dest));
        if (dest != 5'd0) check({tag, ".data"}, rf_data, exp);
        check({tag, ".ready_after"}, 32'(in_ready), 32'd1);
        step();
        check({tag, ".wa_clr"}, 32'(rf_write_addr), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_dest       = '0;
        in_alu_result = '0;
        in_is_load    = 1'b0;
        in_load_type  = '0;
        in_addr_low   = '0;
        mem_rdata     = '0;
        mem_ready     = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_idle_outputs("reset");
        check("reset.data", rf_data, 32'd0);

        // Single non-load
        drive_alu(5'd5, 32'hDEAD_BEEF);
        step();
        in_valid = 1'b0;
        check("alu.wa", 32'(rf_write_addr), 32'd5);
        check("alu.data", rf_data, 32'hDEAD_BEEF);
        step();
        check("alu.wa_clr", 32'(rf_write_addr), 32'd0);

        // Back-to-back non-loads
        drive_alu(5'd3, 32'h1111_2222);
        step();
        check("b2b.wa0", 32'(rf_write_addr), 32'd3);
        check("b2b.data0", rf_data, 32'h1111_2222);
        check("b2b.ready0", 32'(in_ready), 32'd1);
        drive_alu(5'd4, 32'h3333_4444);
        step();
        in_valid = 1'b0;
        check("b2b.wa1", 32'(rf_write_addr), 32'd4);
        check("b2b.data1", rf_data, 32'h3333_4444);
        check("b2b.ready1", 32'(in_ready), 32'd1);
        step();
        check("b2b.wa_clr", 32'(rf_write_addr), 32'd0);

        // mem_ready while idle must not cause a write
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ready = 1'b0;
        check_idle_outputs("idle_mr");

        // Loads with extraction
        run_load("lb3",  3'd0, 2'd3, 5'd7,  2, 32'h8012_3456, 32'hFFFF_FF80);
        run_load("lbu3", 3'd1, 2'd3, 5'd7,  2, 32'h8012_3456, 32'h0000_0080);
        run_load("lh2",  3'd2, 2'd2, 5'd8,  1, 32'h8012_3456, 32'hFFFF_8012);
        run_load("lw0",  3'd4, 2'd0, 5'd9,  0, 32'h8012_3456, 32'h8012_3456);
        run_load("lhu0", 3'd3, 2'd0, 5'd10, 0, 32'h8012_F456, 32'h0000_F456);
        run_load("lb1",  3'd0, 2'd1, 5'd11, 1, 32'h8012_3456, 32'h0000_0034);
        run_load("lt7",  3'd7, 2'd0, 5'd12, 0, 32'hCAFE_0001, 32'hCAFE_0001);
        run_load("d0",   3'd4, 2'd0, 5'd0,  1, 32'h1234_5678, 32'h0);

        // Acceptance in the cycle right after a load write
        drive_load(3'd4, 2'd0, 5'd13);
        step();
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ready = 1'b0;
        check("follow.wa0", 32'(rf_write_addr), 32'd13);
        check("follow.data0", rf_data, 32'h0BAD_F00D);
        drive_alu(5'd14, 32'h0000_0777);
        step();
        in_valid = 1'b0;
        check("follow.wa1", 32'(rf_write_addr), 32'd14);
        check("follow.data1", rf_data, 32'h0000_0777);
        step();

        // Misaligned loads
        drive_load(3'd4, 2'd1, 5'd15);
        step();
        in_valid = 1'b0;
        check("mis_lw.aerr", 32'(addr_error), 32'd1);
        check("mis_lw.wa", 32'(rf_write_addr), 32'd0);
        check("mis_lw.ready", 32'(in_ready), 32'd1);
        step();
        check("mis_lw.aerr_clr", 32'(addr_error), 32'd0);
        drive_load(3'd3, 2'd3, 5'd15);
        step();
        in_valid = 1'b0;
        check("mis_lhu.aerr", 32'(addr_error), 32'd1);
        check("mis_lhu.ready", 32'(in_ready), 32'd1);
        step();
        check("mis_lhu.aerr_clr", 32'(addr_error), 32'd0);

        // Timeout after 4 WAIT_MEM cycles
        drive_load(3'd4, 2'd0, 5'd16);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("to.wait_berr", 32'(bus_error), 32'd0);
            check("to.wait_ready", 32'(in_ready), 32'd0);
            step();
        end
        check("to.last_ready", 32'(in_ready), 32'd0);
        step();
        check("to.berr", 32'(bus_error), 32'd1);
        check("to.wa", 32'(rf_write_addr), 32'd0);
        check("to.ready", 32'(in_ready), 32'd1);
        step();
        check("to.berr_clr", 32'(bus_error), 32'd0);

        // Reset during WAIT_MEM
        drive_load(3'd4, 2'd0, 5'd17);
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h7777_7777;
        check_idle_outputs("rstld");
        check("rstld.data", rf_data, 32'd0);
        step();
        mem_ready = 1'b0;
        check_idle_outputs("rstld_after");
        for (int i = 0; i < 4; i++) step();
        check("rstld.no_berr", 32'(bus_error), 32'd0);

        // Reset overrides acceptance
        rst = 1'b1;
        drive_alu(5'd18, 32'h1234_0000);
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_acc.wa", 32'(rf_write_addr), 32'd0);
        check("rst_acc.data", rf_data, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the CPU; sits directly upstream of the register file and drives its write port.
- Takes retiring instructions from the memory stage: either an ALU result or a pending load.
- For loads, it waits on the data-memory handshake and extracts/extends bytes or halfwords.
- Presents exactly one register-write per retired instruction, and stalls the upstream stage while a load is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT_MEM before the load is abandoned.
- TIMEOUT_W, 8: counter width; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  memory stage presents a retiring instruction.
- in_ready  out  1  stage accepts an instruction this cycle; equals (state==IDLE).
- in_dest  in  5  destination register; 0 = no write.
- in_alu_result  in  32  result for non-load instructions.
- in_is_load  in  1  instruction is a load.
- in_load_type  in  3  load type: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW; 5-7 treated as LW.
- in_addr_low  in  2  effective address bits [1:0].
- mem_rdata  in  32  data-memory read data, little-endian byte lanes.
- mem_ready  in  1  mem_rdata valid; sampled only in WAIT_MEM.
- rf_write_addr  out  5  register-file write address; 0 = no write.
- rf_data  out  32  register-file write data.
- addr_error  out  1  one-cycle pulse: misaligned load dropped.
- bus_error  out  1  one-cycle pulse: load timed out.

Behaviour:
- Reset state:
  - state=IDLE, so in_ready=1.
  - rf_write_addr=0, rf_data=0, addr_error=0, bus_error=0, timeout counter=0.
- Outputs: rf_write_addr, rf_data, addr_error and bus_error are registered. Every write is held for exactly one cycle; rf_write_addr returns to 0 the following cycle unless a new write follows.
- Handshake: an instruction is accepted at a posedge where in_valid && in_ready. Inputs are don't-care otherwise.
- State IDLE, on acceptance:
  - Non-load: next cycle rf_write_addr=in_dest, rf_data=in_alu_result. Latency is 1 cycle, the write commits at the following posedge, and back-to-back acceptance is allowed every cycle.
  - Load, misaligned (LH/LHU with addr_low[0]=1, or LW with addr_low!=0): no write; addr_error=1 next cycle; stay IDLE.
  - Load, aligned: latch dest, type and addr_low; clear counter; go to WAIT_MEM.
- State WAIT_MEM:
  - in_ready=0.
  - mem_ready=1: next cycle rf_write_addr=latched dest, rf_data=extracted value; go to IDLE. A new instruction can be accepted in that same following cycle.
  - mem_ready=0 and counter==TIMEOUT_CYCLES-1: no write; bus_error=1 next cycle; go to IDLE.
  - Otherwise: counter+1.
  - Minimum load latency: acceptance at edge N, mem_ready sampled at edge N+1, write visible in cycle N+2.
- Extraction:
  - Byte k = mem_rdata[8k+7:8k], k = addr_low.
  - Half at offset 0 = [15:0]; offset 2 = [31:16].
  - LB/LH sign-extend to 32; LBU/LHU zero-extend; LW passes the full word.
- in_dest=0: the instruction flows normally (a load still waits for memory), but rf_write_addr stays 0. rf_data is don't-care.
- Reset mid-load: rst in WAIT_MEM returns to IDLE, discards the pending write, clears the counter, and suppresses bus_error.
- rst overrides acceptance in the same cycle.
- mem_ready asserted while IDLE is ignored.

Test Plan:
- Non-load: in_valid=1, dest=5, alu=0xDEADBEEF at edge N -> cycle N+1: rf_write_addr=5, rf_data=0xDEADBEEF; cycle N+2: rf_write_addr=0.
- Back-to-back non-loads to dest 3 then 4 on consecutive edges -> consecutive cycles show (3, A) then (4, B); in_ready stays 1.
- LB, addr_low=3, dest=7, mem_rdata=0x80123456 with mem_ready after 2 wait cycles -> in_ready=0 for 3 cycles, then rf_write_addr=7, rf_data=0xFFFFFF80. Same data with LBU -> 0x00000080. LH, addr_low=2 -> 0xFFFF8012. LW -> 0x80123456.
- LW with addr_low=1 -> no write, addr_error pulse for exactly 1 cycle, in_ready remains 1.
- Load with mem_ready never asserted and TIMEOUT_CYCLES=4 -> bus_error pulse 1 cycle after the 4th WAIT_MEM cycle, no write, in_ready=1 afterwards.
- rst asserted during WAIT_MEM, then mem_ready=1 -> no write, no bus_error, all outputs at reset values.
